// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters; sub-word stores become read-modify-write.
// Latency: load/word store/error ack two cycles after request, sub-word store three; requests wait while busy.
module dmem_arbiter #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [1:0]  size0,
   input  logic [1:0]  size1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        busy,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

   localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merged_q, merged_d;
   logic        err_q, err_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        grant1;
   logic        acc_err;
   logic [4:0]  sh;
   logic [31:0] width_mask;
   logic [31:0] load_val;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [31:0] merge_val;

   // Little-endian lane selection: shift amount is the byte offset in bits.
   assign sh         = {addr_q[1:0], 3'b000};
   assign width_mask = (size_q == 2'b00) ? 32'h0000_00FF :
                       (size_q == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   assign load_val   = (mem_rd >> sh) & width_mask;
   assign lane_mask  = width_mask << sh;
   assign lane_data  = (wdata_q & width_mask) << sh;
   assign merge_val  = (mem_rd & ~lane_mask) | (lane_data & lane_mask);

   assign acc_err = (size_q == 2'b11)
                  | ((size_q == 2'b01) & addr_q[0])
                  | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
                  | (addr_q[31:2] >= DEPTH_W);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      merged_d     = merged_q;
      err_d        = err_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      mem_we       = 1'b0;
      grant1       = req1 & (~req0 | ~last_grant_q);

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               port_d       = grant1;
               last_grant_d = grant1;
               we_d         = grant1 ? we1    : we0;
               size_d       = grant1 ? size1  : size0;
               addr_d       = grant1 ? addr1  : addr0;
               wdata_d      = grant1 ? wdata1 : wdata0;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            err_d   = acc_err;
            state_d = DONE;
            if (acc_err) begin
               if (port_q) rdata1_d = 32'h0; else rdata0_d = 32'h0;
            end else if (!we_q) begin
               if (port_q) rdata1_d = load_val; else rdata0_d = load_val;
            end else if (size_q == 2'b10) begin
               mem_we = 1'b1;
               if (port_q) rdata1_d = 32'h0; else rdata0_d = 32'h0;
            end else begin
               merged_d = merge_val;
               state_d  = MERGE_WR;
            end
         end
         MERGE_WR: begin
            mem_we  = 1'b1;
            state_d = DONE;
            if (port_q) rdata1_d = 32'h0; else rdata0_d = 32'h0;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         merged_q     <= 32'h0;
         err_q        <= 1'b0;
         rdata0_q     <= 32'h0;
         rdata1_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         merged_q     <= merged_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign mem_a  = {addr_q[31:2], 2'b00};
   assign mem_wd = (state_q == MERGE_WR) ? merged_q : wdata_q;
   assign ack0   = (state_q == DONE) & ~port_q;
   assign ack1   = (state_q == DONE) &  port_q;
   assign err0   = ack0 & err_q;
   assign err1   = ack1 & err_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;
   assign busy   = (state_q != IDLE);

endmodule
